// File: rtl/writeback_unit_if.sv
// Writeback stage bundle: instruction fields from MEM,
// load response, and the stall back to upstream.
interface writeback_unit_if #(
  parameter int XLEN = 32
);
  logic            valid_WB;
  logic [1:0]      result_set_WB;
  logic            reg_write_WB;
  logic [4:0]      rd_WB;
  logic [2:0]      funct3_WB;
  logic [XLEN-1:0] alu_result_WB;
  logic [XLEN-1:0] imm_ext_WB;
  logic [XLEN-1:0] pcPlus4_WB;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_data;
  logic            stall_WB;

  modport master (
    output valid_WB, result_set_WB, reg_write_WB,
    output rd_WB, funct3_WB, alu_result_WB,
    output imm_ext_WB, pcPlus4_WB,
    output mem_rsp_valid, mem_rsp_data,
    input  stall_WB
  );

  modport slave (
    input  valid_WB, result_set_WB, reg_write_WB,
    input  rd_WB, funct3_WB, alu_result_WB,
    input  imm_ext_WB, pcPlus4_WB,
    input  mem_rsp_valid, mem_rsp_data,
    output stall_WB
  );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: result select, load extraction,
// memory-wait stall, registered RF write, retire counter.
module writeback_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  writeback_unit_if.slave  wb,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic [CNT_W-1:0] retired_count
);
  localparam int OW = (XLEN == 64) ? 3 : 2;

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t          state_q, state_d;
  logic            is_load, commit, stall;
  logic [2:0]      off_b, off_h, off_w;
  logic [XLEN-1:0] sh_b, sh_h, sh_w;
  logic [XLEN-1:0] ld_val, res;

  assign is_load = wb.valid_WB &&
                   (wb.result_set_WB == 2'b01);
  assign wb.stall_WB = stall;

  // next state, stall and commit decision
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (is_load && !wb.mem_rsp_valid) begin
          state_d = WAIT_MEM;
          stall   = 1'b1;
        end else begin
          commit = wb.valid_WB;
        end
      end
      WAIT_MEM: begin
        if (wb.mem_rsp_valid) begin
          state_d = IDLE;
          commit  = 1'b1;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // byte offsets, aligned down per access size
  always_comb begin
    off_b = '0;
    off_b[OW-1:0] = wb.alu_result_WB[OW-1:0];
    off_h = off_b & 3'b110;
    off_w = off_b & 3'b100;
  end

  assign sh_b = wb.mem_rsp_data >> {off_b, 3'b000};
  assign sh_h = wb.mem_rsp_data >> {off_h, 3'b000};
  assign sh_w = wb.mem_rsp_data >> {off_w, 3'b000};

  // load size and sign extension
  always_comb begin
    ld_val = XLEN'($signed(sh_w[31:0]));
    unique case (wb.funct3_WB)
      3'b000: ld_val = XLEN'($signed(sh_b[7:0]));
      3'b001: ld_val = XLEN'($signed(sh_h[15:0]));
      3'b100: ld_val = XLEN'(sh_b[7:0]);
      3'b101: ld_val = XLEN'(sh_h[15:0]);
      3'b110: ld_val = XLEN'(sh_w[31:0]);
      3'b011: begin
        if (XLEN == 64) ld_val = wb.mem_rsp_data;
      end
      default: ;
    endcase
  end

  // result source select
  always_comb begin
    res = wb.alu_result_WB;
    unique case (wb.result_set_WB)
      2'b00: res = wb.alu_result_WB;
      2'b01: res = ld_val;
      2'b10: res = wb.pcPlus4_WB;
      2'b11: res = wb.imm_ext_WB;
      default: ;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // registered RF write; addr/data hold when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (commit) begin
      rf_we    <= wb.reg_write_WB &&
                  (wb.rd_WB != 5'd0);
      rf_waddr <= wb.rd_WB;
      rf_wdata <= res;
    end else begin
      rf_we <= 1'b0;
    end
  end

  // retired-instruction counter, wraps naturally
  always_ff @(posedge clk) begin
    if (reset)       retired_count <= '0;
    else if (commit) retired_count <= retired_count + 1'b1;
  end
endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: protocol-level model
// plus hand-computed literal expectations.
module tb_writeback_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rf_we, rf_we4;
  logic [4:0]  rf_waddr, rf_waddr4;
  logic [31:0] rf_wdata, rf_wdata4;
  logic [63:0] cnt;
  logic [3:0]  cnt4;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  writeback_unit_if #(.XLEN(32)) bus ();
  writeback_unit_if #(.XLEN(32)) bus4 ();

  assign bus4.valid_WB      = bus.valid_WB;
  assign bus4.result_set_WB = bus.result_set_WB;
  assign bus4.reg_write_WB  = bus.reg_write_WB;
  assign bus4.rd_WB         = bus.rd_WB;
  assign bus4.funct3_WB     = bus.funct3_WB;
  assign bus4.alu_result_WB = bus.alu_result_WB;
  assign bus4.imm_ext_WB    = bus.imm_ext_WB;
  assign bus4.pcPlus4_WB    = bus.pcPlus4_WB;
  assign bus4.mem_rsp_valid = bus.mem_rsp_valid;
  assign bus4.mem_rsp_data  = bus.mem_rsp_data;

  writeback_unit #(.XLEN(32), .CNT_W(64)) dut (
    .clk(clk), .reset(reset), .wb(bus.slave),
    .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .retired_count(cnt)
  );

  writeback_unit #(.XLEN(32), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .wb(bus4.slave),
    .rf_we(rf_we4), .rf_waddr(rf_waddr4),
    .rf_wdata(rf_wdata4), .retired_count(cnt4)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h",
                  name, act, exp);
  endtask

  // load extraction from a byte-lane view of the word
  function automatic logic [31:0] extract(
    logic [2:0] f3, logic [31:0] addr, logic [31:0] d);
    logic [7:0] by [4];
    logic [15:0] h;
    int o;
    for (int i = 0; i < 4; i++) by[i] = d[8*i +: 8];
    o = int'(addr[1:0]);
    case (f3)
      3'b000: return {{24{by[o][7]}}, by[o]};
      3'b100: return {24'h0, by[o]};
      3'b001, 3'b101: begin
        o = o - (o % 2);
        h = {by[o+1], by[o]};
        if (f3 == 3'b001) return {{16{h[15]}}, h};
        return {16'h0, h};
      end
      default: return d;
    endcase
  endfunction

  logic        m_we = 1'b0;
  logic [4:0]  m_waddr = '0;
  logic [31:0] m_wdata = '0;
  logic [63:0] m_cnt = '0;

  // model: what a commit must produce next cycle
  always @(posedge clk) begin
    if (reset) begin
      m_we <= 1'b0; m_waddr <= '0;
      m_wdata <= '0; m_cnt <= '0;
    end else if (bus.valid_WB &&
                 (bus.result_set_WB != 2'b01 ||
                  bus.mem_rsp_valid)) begin
      m_we <= bus.reg_write_WB && bus.rd_WB != 0;
      m_waddr <= bus.rd_WB;
      case (bus.result_set_WB)
        2'b00: m_wdata <= bus.alu_result_WB;
        2'b01: m_wdata <= extract(bus.funct3_WB,
                  bus.alu_result_WB, bus.mem_rsp_data);
        2'b10: m_wdata <= bus.pcPlus4_WB;
        default: m_wdata <= bus.imm_ext_WB;
      endcase
      m_cnt <= m_cnt + 1;
    end else begin
      m_we <= 1'b0;
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rf_we", 64'(rf_we), 64'(m_we));
      chk("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
      chk("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
      chk("count", cnt, m_cnt);
      chk("count4", 64'(cnt4), 64'(m_cnt[3:0]));
      chk("stall", 64'(bus.stall_WB),
          64'(bus.valid_WB && bus.result_set_WB == 2'b01
              && !bus.mem_rsp_valid));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(bit v, bit [1:0] rs, bit rw,
                     bit [4:0] rd, bit [2:0] f3,
                     bit [31:0] alu, bit [31:0] imm,
                     bit [31:0] pc4, bit rv,
                     bit [31:0] rdata);
    bus.valid_WB = v;
    bus.result_set_WB = rs;
    bus.reg_write_WB = rw;
    bus.rd_WB = rd;
    bus.funct3_WB = f3;
    bus.alu_result_WB = alu;
    bus.imm_ext_WB = imm;
    bus.pcPlus4_WB = pc4;
    bus.mem_rsp_valid = rv;
    bus.mem_rsp_data = rdata;
  endtask

  task automatic ld(bit [4:0] rd, bit [2:0] f3,
                    bit [31:0] a, bit rv, bit [31:0] d);
    put(1, 2'b01, 1, rd, f3, a, 0, 0, rv, d);
  endtask

  task automatic lcase(string nm, bit [2:0] f3,
                       bit [31:0] a, bit [31:0] want);
    ld(5'd8, f3, a, 1, 32'h80FF_7F01);
    #1 chk({nm, "_stall"}, 64'(bus.stall_WB), 64'd0);
    tick();
    chk(nm, 64'(rf_wdata), 64'(want));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_wdata", 64'(rf_wdata), 64'd0);
    chk("rst_cnt", cnt, 64'd0);
    chk("rst_stall", 64'(bus.stall_WB), 64'd0);

    put(1, 2'b00, 1, 5, 0, 32'h1234, 0, 0, 0, 0);
    tick();
    chk("alu_we", 64'(rf_we), 64'd1);
    chk("alu_waddr", 64'(rf_waddr), 64'd5);
    chk("alu_wdata", 64'(rf_wdata), 64'h1234);
    chk("alu_cnt", cnt, 64'd1);
    put(1, 2'b11, 1, 6, 0, 0, 32'hABCD_E000, 0, 0, 0);
    tick();
    chk("lui_wdata", 64'(rf_wdata), 64'hABCD_E000);
    chk("lui_cnt", cnt, 64'd2);
    put(1, 2'b10, 1, 1, 0, 0, 0, 32'h104, 0, 0);
    tick();
    chk("jal_wdata", 64'(rf_wdata), 64'h104);
    chk("jal_cnt", cnt, 64'd3);
    put(1, 2'b00, 1, 0, 0, 32'h77, 0, 0, 0, 0);
    tick();
    chk("rd0_we", 64'(rf_we), 64'd0);
    chk("rd0_cnt", cnt, 64'd4);

    lcase("LB", 3'b000, 32'h1003, 32'hFFFF_FF80);
    lcase("LBU", 3'b100, 32'h1003, 32'h0000_0080);
    lcase("LH", 3'b001, 32'h1002, 32'hFFFF_80FF);
    lcase("LHU", 3'b101, 32'h1000, 32'h0000_7F01);
    lcase("LW", 3'b010, 32'h1000, 32'h80FF_7F01);
    lcase("LH_odd", 3'b001, 32'h1003, 32'hFFFF_80FF);
    lcase("LB1", 3'b000, 32'h1001, 32'h0000_007F);
    lcase("LW_mis", 3'b010, 32'h1002, 32'h80FF_7F01);
    lcase("LWU", 3'b110, 32'h1000, 32'h80FF_7F01);
    lcase("F011", 3'b011, 32'h1000, 32'h80FF_7F01);
    lcase("F111", 3'b111, 32'h1000, 32'h80FF_7F01);

    ld(7, 3'b010, 32'h2000, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("wait_stall", 64'(bus.stall_WB), 64'd1);
      tick();
      chk("wait_we", 64'(rf_we), 64'd0);
    end
    chk("wait_cnt", cnt, 64'd15);
    ld(7, 3'b010, 32'h2000, 1, 32'hDEAD_BEEF);
    #1 chk("rsp_stall", 64'(bus.stall_WB), 64'd0);
    tick();
    chk("rsp_we", 64'(rf_we), 64'd1);
    chk("rsp_waddr", 64'(rf_waddr), 64'd7);
    chk("rsp_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
    chk("rsp_cnt", cnt, 64'd16);

    ld(9, 3'b010, 32'h3000, 0, 32'h0);
    tick();
    ld(9, 3'b010, 32'h3000, 1, 32'h1111_2222);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("mrst_we", 64'(rf_we), 64'd0);
    chk("mrst_cnt", cnt, 64'd0);
    #1 chk("mrst_stall", 64'(bus.stall_WB), 64'd0);
    tick();
    chk("mrst_we2", 64'(rf_we), 64'd0);

    put(1, 2'b00, 1, 3, 0, 32'h55, 0, 0, 1, 32'hFFFF);
    tick();
    chk("stray_wdata", 64'(rf_wdata), 64'h55);
    chk("stray_cnt", cnt, 64'd1);
    put(0, 2'b00, 1, 4, 0, 32'h66, 0, 0, 1, 32'hFFFF);
    tick();
    chk("stray_we", 64'(rf_we), 64'd0);
    chk("stray_hold", 64'(rf_wdata), 64'h55);

    for (int i = 0; i < 16; i++) begin
      put(1, 2'b00, 1, 5'(i + 1), 0, 32'(i * 3),
          0, 0, 0, 0);
      tick();
    end
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("wrap_cnt4", 64'(cnt4), 64'd1);
    chk("wrap_cnt", cnt, 64'd17);
    tick();
    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
